reset_sequencer: RTL
====================

# reset_sequencer

Central reset generator for the NPC core. It takes the board-level asynchronous reset and a synchronous software reset request, and synchronizes the release of the board reset. It then de-asserts per-domain reset lines one at a time in a fixed order with a programmable hold gap between stages. The per-domain reset lines feed the state registers, the regfile/memory model and the fetch front end. Downstream registers receive a reset that is already clean, ordered and glitch-free.

## Interface
- NUM_STAGES, 3: number of reset domains; must be ≥1.
- HOLD_CYCLES, 4: cycles between consecutive releases; must be ≥1.
- SYNC_STAGES, 2: flops in the rst release synchronizer; must be ≥2.
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-high reset; clock clk.
- sw_rst_req  input  1  synchronous software reset request, level-sampled on each clk rising edge.
- rst_out  output  NUM_STAGES  per-domain active-high resets; bit 0 releases first, bit NUM_STAGES-1 releases last.
- busy  output  1  high while any rst_out bit is high.
- done  output  1  one-cycle pulse when the last stage releases.
- sw_rst_count  output  8  number of accepted software reset requests, saturating.

## Operation
- States: SYNC, WAIT, RUN. Internal counters:
  - cnt: width clog2(HOLD_CYCLES), or 1 if HOLD_CYCLES=1.
  - idx: width clog2(NUM_STAGES+1).
- While rst=1, the following apply asynchronously with no clock needed:
  - rst_out = all ones, busy=1, done=0, sw_rst_count=0.
  - The synchronizer chain is cleared, state=SYNC, cnt=0, idx=0.
- SYNC:
  - After rst falls, a 1 shifts through the SYNC_STAGES-flop chain.
  - On the edge where the last flop becomes 1, the state moves to WAIT with cnt=0.
  - sw_rst_req is ignored in SYNC.
- WAIT:
  - Each edge with cnt≠HOLD_CYCLES-1 increments cnt.
  - On the edge with cnt=HOLD_CYCLES-1: rst_out[idx] is cleared, cnt becomes 0, idx increments.
  - If idx was NUM_STAGES-1, the state moves to RUN, busy goes to 0 and done is 1 for the following cycle.
- RUN: all rst_out=0. done is 0 except for the single cycle after entry.
- Software reset, when sw_rst_req=1 on an edge in WAIT or RUN:
  - rst_out becomes all ones, cnt=0, idx=0, state=WAIT, busy=1.
  - done is suppressed, including when the request coincides with the final-release edge: software reset takes priority and no done pulse is issued.
  - sw_rst_count increments, saturating at 255.
- A held sw_rst_req counts as one request per cycle. Each such cycle restarts the sequence and increments sw_rst_count.
- A software reset skips SYNC, because it is already synchronous to clk.
- Release order is strictly ascending bit index. Once a bit is released it stays low until the next reset of either kind. The bits of rst_out therefore always form a contiguous high group at the top.
- All outputs are registered, with no combinational path from inputs to outputs.

## Timing
- Reset values: rst_out=all ones, busy=1, done=0, sw_rst_count=0.
- Count edges from 1, starting at the first rising edge after rst falls:
  - Edge SYNC_STAGES enters WAIT.
  - Stage k releases at edge SYNC_STAGES + (k+1)·HOLD_CYCLES.
  - With the defaults, stages release at edges 6, 10 and 14. done is high for the cycle after edge 14.
- For a software reset sampled at edge T, stage k releases at edge T + (k+1)·HOLD_CYCLES.
- With HOLD_CYCLES=1, stages release on consecutive edges.
- If rst asserts at any point in any state, all outputs return to their reset values immediately and the sequence restarts from SYNC.
- A rst pulse shorter than one clock period still fully resets the block and rst_out.
- rst de-assertion is never propagated to rst_out in the same cycle.

## Test plan
- Power-on with default parameters: hold rst for 3 cycles, then release. rst_out must be 111 through edge 5, then 110 after edge 6, 100 after edge 10 and 000 after edge 14. done must be high for exactly the cycle after edge 14, busy must be 0 from edge 14 and sw_rst_count must be 0.
- sw_rst_req pulsed for one cycle at edge T while in RUN: rst_out must be 111 after T, then 110 after T+4, 100 after T+8 and 000 after T+12. sw_rst_count must be 1 and done must pulse once.
- sw_rst_req asserted at T+5 during a running sequence, with rst_out at 110: rst_out must return to 111 and releases must occur at T+9, T+13 and T+17. sw_rst_count must be 2 and done must not pulse before T+17.
- rst pulsed asynchronously for half a clock period mid-WAIT: rst_out must become 111 and sw_rst_count 0 before the next edge, and the sequence must restart with releases at edges 6, 10 and 14 after rst falls.
- sw_rst_req held high for 300 cycles, then dropped at edge T: sw_rst_count must saturate at 255 without wrapping, rst_out must stay 111 throughout the hold, and the first release must occur 4 edges after the last high sample.
- NUM_STAGES=1 with HOLD_CYCLES=1 after power-on: rst_out must be 1 through edge 2 and 0 after edge 3, and done must be high for the cycle after edge 3.

Source files
------------

// File: rtl/reset_sequencer.sv
// reset_sequencer: central reset generator.
// Synchronizes the release of the board reset, then releases the per-domain
// resets one at a time (bit 0 first) with HOLD_CYCLES clocks between releases.
// A synchronous software reset restarts the release sequence without going
// through the synchronizer. All outputs are registered.
module reset_sequencer #(
  parameter int NUM_STAGES  = 3,
  parameter int HOLD_CYCLES = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  sw_rst_req,
  output logic [NUM_STAGES-1:0] rst_out,
  output logic                  busy,
  output logic                  done,
  output logic [7:0]            sw_rst_count
);

  localparam int CW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam int IW = $clog2(NUM_STAGES + 1);

  typedef enum logic [1:0] {S_SYNC, S_WAIT, S_RUN} state_t;

  state_t                  state_q, state_d;
  logic [SYNC_STAGES-1:0]  sync_q, sync_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic [NUM_STAGES-1:0]   rst_out_q, rst_out_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic [7:0]              swcnt_q, swcnt_d;

  // State register; board reset forces every output to its reset value at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_SYNC;
      sync_q    <= '0;
      cnt_q     <= '0;
      idx_q     <= '0;
      rst_out_q <= '1;
      busy_q    <= 1'b1;
      done_q    <= 1'b0;
      swcnt_q   <= '0;
    end else begin
      state_q   <= state_d;
      sync_q    <= sync_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      rst_out_q <= rst_out_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      swcnt_q   <= swcnt_d;
    end
  end

  // Next-state: synchronizer, hold counter, ordered release, software restart.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    rst_out_d = rst_out_q;
    swcnt_d   = swcnt_q;
    done_d    = 1'b0;
    // A 1 marches through the chain once rst is gone; it saturates at all ones.
    sync_d    = {sync_q[SYNC_STAGES-2:0], 1'b1};

    case (state_q)
      S_SYNC: begin
        // Leave on the edge where the last synchronizer flop first goes high.
        if (sync_d[SYNC_STAGES-1] && !sync_q[SYNC_STAGES-1]) begin
          state_d = S_WAIT;
          cnt_d   = '0;
        end
      end
      S_WAIT: begin
        if (cnt_q == CW'(HOLD_CYCLES - 1)) begin
          cnt_d = '0;
          idx_d = idx_q + 1'b1;
          for (int i = 0; i < NUM_STAGES; i++) begin
            if (idx_q == IW'(i)) rst_out_d[i] = 1'b0;
          end
          if (idx_q == IW'(NUM_STAGES - 1)) begin
            state_d = S_RUN;
            done_d  = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_RUN: begin
        rst_out_d = '0;
      end
      default: begin
        state_d = S_SYNC;
      end
    endcase

    // Software reset wins over a coinciding final release (no done pulse).
    if (sw_rst_req && (state_q != S_SYNC)) begin
      state_d   = S_WAIT;
      rst_out_d = '1;
      cnt_d     = '0;
      idx_d     = '0;
      done_d    = 1'b0;
      if (swcnt_q != 8'hFF) swcnt_d = swcnt_q + 8'd1;
    end

    busy_d = |rst_out_d;
  end

  assign rst_out      = rst_out_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign sw_rst_count = swcnt_q;

endmodule
